// File: rtl/mips_data_mem_responder_pkg.sv
// Shared types for the data-memory responder: byte lanes, FSM states and a lane packer.
package mips_mem_pkg;

    typedef logic [7:0]   byte_t;
    typedef byte_t [0:3]  lanes_t;

    typedef enum logic [1:0] {
        StInit,
        StServe,
        StDump,
        StDone
    } state_e;

    // Lane 0 lands in the most significant byte.
    function automatic logic [31:0] pack_lanes(input lanes_t l);
        return {l[0], l[1], l[2], l[3]};
    endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Core data-memory port plus the valid/ready dump channel of the responder.
interface mips_data_mem_responder_if #(
    parameter int unsigned ADDR_BITS = 12
) ();
    import mips_mem_pkg::*;

    logic [31:0]          mem_addr;
    lanes_t               mem_data_in;
    logic                 mem_write_en;
    lanes_t               mem_data_out;

    logic                 dump_valid;
    logic                 dump_ready;
    logic [ADDR_BITS-1:0] dump_addr;
    logic [31:0]          dump_data;

    modport master (
        output mem_addr, mem_data_in, mem_write_en, dump_ready,
        input  mem_data_out, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_write_en, dump_ready,
        output mem_data_out, dump_valid, dump_addr, dump_data
    );

endinterface

// File: rtl/mips_byte_ram.sv
// Byte-wide RAM with four wrapping combinational read lanes, a 4-lane write port
// and an aligned word port used by the clear and dump sweeps.
module mips_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 clk_i,
    input  logic [ADDR_BITS-1:0] lane_addr_i,
    output lanes_t               lane_rdata_o,
    input  logic                 lane_we_i,
    input  lanes_t               lane_wdata_i,
    input  logic                 word_we_i,
    input  logic [ADDR_BITS-3:0] word_idx_i,
    input  logic [31:0]          word_wdata_i,
    output logic [31:0]          word_rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    byte_t                mem_q [Depth];
    logic [ADDR_BITS-1:0] lane_addr [4];
    lanes_t               word_lanes;

    // Lane addresses wrap modulo the array size.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i]    = lane_addr_i + ADDR_BITS'(i);
            lane_rdata_o[i] = mem_q[lane_addr[i]];
        end
    end

    always_comb begin
        word_lanes[0] = mem_q[{word_idx_i, 2'b00}];
        word_lanes[1] = mem_q[{word_idx_i, 2'b01}];
        word_lanes[2] = mem_q[{word_idx_i, 2'b10}];
        word_lanes[3] = mem_q[{word_idx_i, 2'b11}];
        word_rdata_o  = pack_lanes(word_lanes);
    end

    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            mem_q[{word_idx_i, 2'b00}] <= word_wdata_i[31:24];
            mem_q[{word_idx_i, 2'b01}] <= word_wdata_i[23:16];
            mem_q[{word_idx_i, 2'b10}] <= word_wdata_i[15:8];
            mem_q[{word_idx_i, 2'b11}] <= word_wdata_i[7:0];
        end else if (lane_we_i) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[lane_addr[i]] <= lane_wdata_i[i];
            end
        end
    end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder: clears the RAM after reset, serves the core, then
// streams every word out over the dump channel once the core halts.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                         clk,
    input  logic                         rst_b,
    mips_data_mem_responder_if.slave     bus,
    input  logic                         halted,
    output logic                         ready,
    output logic                         dump_done,
    output logic                         oor_err,
    output logic                         drop_err,
    output logic [15:0]                  wr_count
);

    localparam int unsigned PtrBits = ADDR_BITS - 2;
    localparam logic [PtrBits-1:0] LastPtr = {PtrBits{1'b1}};

    state_e               state_q, state_d;
    logic [PtrBits-1:0]   init_ptr_q, init_ptr_d;
    logic [PtrBits-1:0]   dump_ptr_q, dump_ptr_d;
    logic                 halted_q;
    logic                 dump_valid_q, dump_valid_d;
    logic                 dump_done_q, dump_done_d;
    logic [ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
    logic [31:0]          dump_data_q, dump_data_d;
    logic                 oor_q, oor_d;
    logic                 drop_q, drop_d;
    logic [15:0]          wr_count_q, wr_count_d;

    logic                 lane_we;
    logic                 word_we;
    logic [PtrBits-1:0]   word_idx;
    logic [31:0]          word_rdata;
    lanes_t               rd_lanes;
    logic                 halt_rise;
    logic                 upper_nz;

    mips_byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk_i        (clk),
        .lane_addr_i  (bus.mem_addr[ADDR_BITS-1:0]),
        .lane_rdata_o (rd_lanes),
        .lane_we_i    (lane_we),
        .lane_wdata_i (bus.mem_data_in),
        .word_we_i    (word_we),
        .word_idx_i   (word_idx),
        .word_wdata_i (32'h0),
        .word_rdata_o (word_rdata)
    );

    assign halt_rise = halted & ~halted_q;
    assign upper_nz  = |bus.mem_addr[31:ADDR_BITS];

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        dump_ptr_d   = dump_ptr_q;
        dump_valid_d = dump_valid_q;
        dump_done_d  = dump_done_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        oor_d        = oor_q;
        drop_d       = drop_q;
        wr_count_d   = wr_count_q;
        lane_we      = 1'b0;
        word_we      = 1'b0;
        word_idx     = dump_ptr_q;

        if (bus.mem_write_en && (state_q != StServe)) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            StInit: begin
                word_we    = 1'b1;
                word_idx   = init_ptr_q;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LastPtr) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                if (bus.mem_write_en) begin
                    lane_we = 1'b1;
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                    if (upper_nz) begin
                        oor_d = 1'b1;
                    end
                end
                // Dump starts one cycle later so word 0 reflects a same-edge write.
                if (halt_rise) begin
                    state_d      = StDump;
                    dump_ptr_d   = '0;
                    dump_valid_d = 1'b0;
                end
            end
            StDump: begin
                if (!dump_valid_q) begin
                    word_idx     = dump_ptr_q;
                    dump_valid_d = 1'b1;
                    dump_addr_d  = {dump_ptr_q, 2'b00};
                    dump_data_d  = word_rdata;
                end else if (bus.dump_ready) begin
                    if (dump_ptr_q == LastPtr) begin
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                        state_d      = StDone;
                    end else begin
                        word_idx    = dump_ptr_q + 1'b1;
                        dump_ptr_d  = word_idx;
                        dump_addr_d = {word_idx, 2'b00};
                        dump_data_d = word_rdata;
                    end
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StInit;
            init_ptr_q   <= '0;
            dump_ptr_q   <= '0;
            halted_q     <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            oor_q        <= 1'b0;
            drop_q       <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            dump_ptr_q   <= dump_ptr_d;
            halted_q     <= halted;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            oor_q        <= oor_d;
            drop_q       <= drop_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign bus.mem_data_out = (state_q == StInit) ? '0 : rd_lanes;
    assign bus.dump_valid   = dump_valid_q;
    assign bus.dump_addr    = dump_addr_q;
    assign bus.dump_data    = dump_data_q;
    assign ready            = (state_q != StInit);
    assign dump_done        = dump_done_q;
    assign oor_err          = oor_q;
    assign drop_err         = drop_q;
    assign wr_count         = wr_count_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder with a 256-byte array.
module tb_mips_data_mem_responder;

    localparam int unsigned AB = 8;
    localparam int unsigned NW = 64;

    logic        clk;
    logic        rst_b;
    logic        halted;
    logic        ready;
    logic        dump_done;
    logic        oor_err;
    logic        drop_err;
    logic [15:0] wr_count;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [31:0] exp_word [NW];

    mips_data_mem_responder_if #(.ADDR_BITS(AB)) bus ();

    mips_data_mem_responder #(
        .ADDR_BITS (AB)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus),
        .halted    (halted),
        .ready     (ready),
        .dump_done (dump_done),
        .oor_err   (oor_err),
        .drop_err  (drop_err),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(ready), 32'h0);
        check_eq({tag, "_dvalid"}, 32'(bus.dump_valid), 32'h0);
        check_eq({tag, "_ddone"}, 32'(dump_done), 32'h0);
        check_eq({tag, "_daddr"}, 32'(bus.dump_addr), 32'h0);
        check_eq({tag, "_ddata"}, bus.dump_data, 32'h0);
        check_eq({tag, "_oor"}, 32'(oor_err), 32'h0);
        check_eq({tag, "_drop"}, 32'(drop_err), 32'h0);
        check_eq({tag, "_wrcnt"}, 32'(wr_count), 32'h0);
    endtask

    // Counts posedges after reset release until ready; optionally writes at posedge 5.
    task automatic wait_ready(input bit inject, output int n);
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (inject && c == 4) begin
                bus.mem_addr     = 32'h20;
                bus.mem_data_in  = 32'hCAFEF00D;
                bus.mem_write_en = 1'b1;
            end else begin
                bus.mem_write_en = 1'b0;
            end
            if (ready) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_addr     = addr;
        bus.mem_data_in  = data;
        bus.mem_write_en = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.mem_addr = addr;
        #1;
        check_eq(tag, bus.mem_data_out, exp);
    endtask

    task automatic run_dump(input int stop_at);
        int hs;
        hs = 0;
        for (int c = 0; c < 2000 && hs < stop_at; c++) begin
            @(posedge clk);
            #1;
            bus.dump_ready = 1'($urandom_range(0, 1));
            if (bus.dump_valid) begin
                check_eq("dump_addr", 32'(bus.dump_addr), 32'(hs * 4));
                check_eq("dump_data", bus.dump_data, exp_word[hs]);
                if (bus.dump_ready) hs++;
            end
        end
        check_eq("dump_handshakes", 32'(hs), 32'(stop_at));
        @(posedge clk);
        #1;
        bus.dump_ready = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_b            = 1'b0;
        halted           = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        bus.dump_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        check_eq("rst_rdata", bus.mem_data_out, 32'h0);

        rst_b = 1'b1;
        wait_ready(1'b1, cyc);
        check_eq("ready_latency", 32'(cyc), 32'd64);
        check_eq("init_drop", 32'(drop_err), 32'h1);
        check_eq("init_wrcnt", 32'(wr_count), 32'h0);
        rd("rd_00", 32'h00, 32'h0);
        rd("rd_fc", 32'hFC, 32'h0);
        rd("rd_20_dropped", 32'h20, 32'h0);

        wr(32'h10, 32'hDEADBEEF);
        rd("rd_10", 32'h10, 32'hDEADBEEF);
        rd("rd_11", 32'h11, 32'hADBEEF00);
        check_eq("wrcnt_1", 32'(wr_count), 32'd1);

        wr(32'hFE, 32'h11223344);
        rd("rd_wrap_00", 32'h00, 32'h33440000);
        rd("rd_fe", 32'hFE, 32'h11223344);
        check_eq("oor_before", 32'(oor_err), 32'h0);
        wr(32'h100, 32'h55667788);
        check_eq("oor_after", 32'(oor_err), 32'h1);
        rd("rd_oor_00", 32'h00, 32'h55667788);
        rd("rd_upper_ignored", 32'h300, 32'h55667788);
        check_eq("wrcnt_3", 32'(wr_count), 32'd3);
        check_eq("serve_no_dvalid", 32'(bus.dump_valid), 32'h0);

        for (int i = 0; i < NW; i++) exp_word[i] = 32'h0;
        exp_word[0]  = 32'h55667788;
        exp_word[4]  = 32'hDEADBEEF;
        exp_word[63] = 32'h00001122;

        halted = 1'b1;
        run_dump(NW);
        check_eq("done_flag", 32'(dump_done), 32'h1);
        check_eq("done_dvalid", 32'(bus.dump_valid), 32'h0);
        wr(32'h30, 32'h12345678);
        rd("rd_done_write_dropped", 32'h30, 32'h0);
        rd("rd_done_10", 32'h10, 32'hDEADBEEF);
        check_eq("done_wrcnt", 32'(wr_count), 32'd3);

        // Second pass: reset asynchronously in the middle of a dump.
        rst_b  = 1'b0;
        halted = 1'b0;
        #1;
        check_reset_vals("rst2");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        wait_ready(1'b0, cyc);
        check_eq("ready_latency2", 32'(cyc), 32'd64);
        wr(32'h104, 32'hA1A2A3A4);
        check_eq("oor2", 32'(oor_err), 32'h1);
        check_eq("drop2", 32'(drop_err), 32'h0);
        check_eq("wrcnt2", 32'(wr_count), 32'd1);
        for (int i = 0; i < NW; i++) exp_word[i] = 32'h0;
        exp_word[1] = 32'hA1A2A3A4;
        halted = 1'b1;
        run_dump(20);
        check_eq("mid_dvalid", 32'(bus.dump_valid), 32'h1);
        check_eq("mid_daddr", 32'(bus.dump_addr), 32'd80);
        #1;
        rst_b  = 1'b0;
        halted = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        wait_ready(1'b0, cyc);
        check_eq("ready_latency3", 32'(cyc), 32'd64);
        for (int i = 0; i < NW; i++) exp_word[i] = 32'h0;
        halted = 1'b1;
        run_dump(NW);
        check_eq("done_flag3", 32'(dump_done), 32'h1);
        check_eq("done_dvalid3", 32'(bus.dump_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
